// File: rtl/alu_arbiter_if.sv
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request, ALU-side and response signals of the two-port ALU arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_arbiter_if #(
   parameter int DATA_W = 32
);
   logic [1:0]             req_valid_i;
   logic [1:0]             req_ready_o;
   logic [1:0][DATA_W-1:0] req_a_i;
   logic [1:0][DATA_W-1:0] req_b_i;
   logic [1:0][3:0]        req_op_i;

   logic [DATA_W-1:0]      alu_a_o;
   logic [DATA_W-1:0]      alu_b_o;
   logic [3:0]             alu_op_o;
   logic [DATA_W-1:0]      alu_data_i;

   logic                   rsp_valid_o;
   logic                   rsp_ready_i;
   logic [DATA_W-1:0]      rsp_data_o;
   logic                   rsp_id_o;
   logic                   rsp_err_o;

   // Arbiter side
   modport slave (
      input  req_valid_i, req_a_i, req_b_i, req_op_i, alu_data_i, rsp_ready_i,
      output req_ready_o, alu_a_o, alu_b_o, alu_op_o,
      output rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
   );

   // Requester / ALU side
   modport master (
      output req_valid_i, req_a_i, req_b_i, req_op_i, alu_data_i, rsp_ready_i,
      input  req_ready_o, alu_a_o, alu_b_o, alu_op_o,
      input  rsp_valid_o, rsp_data_o, rsp_id_o, rsp_err_o
   );
endinterface

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module   : alu_arbiter
// Brief    : Round-robin share of one 32-bit ALU between two requesters, one
//            operation in flight. Optional opcode check: ALU_ARB_OPCHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter #(
   parameter int DATA_W = 32
) (
   input  logic          clk_i,
   input  logic          rst_i,
   alu_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   logic                r_prio;
   logic                r_id;
   logic                r_err;
   logic [DATA_W-1:0]   r_a;
   logic [DATA_W-1:0]   r_b;
   logic [3:0]          r_op;
   logic [DATA_W-1:0]   r_data;

   logic                w_grant_id;
   logic [1:0]          w_ready;
   logic                w_req_hs;
   logic [DATA_W-1:0]   w_a_sel;
   logic [DATA_W-1:0]   w_b_sel;
   logic [3:0]          w_op_sel;
   logic [3:0]          w_op_cap;
   logic                w_op_err;

   // Winner is the sole valid requester, or the priority holder on a tie
   always_comb begin
      w_grant_id = r_prio;
      case (bus.req_valid_i)
         2'b01:   w_grant_id = 1'b0;
         2'b10:   w_grant_id = 1'b1;
         default: w_grant_id = r_prio;
      endcase
   end

   assign w_a_sel  = bus.req_a_i[w_grant_id];
   assign w_b_sel  = bus.req_b_i[w_grant_id];
   assign w_op_sel = bus.req_op_i[w_grant_id];

`ifdef ALU_ARB_OPCHECK_EN
   assign w_op_err = (w_op_sel > 4'd9);
   assign w_op_cap = w_op_err ? 4'd0 : w_op_sel;
`else
   assign w_op_err = 1'b0;
   assign w_op_cap = w_op_sel;
`endif

   always_comb begin
      w_state_next = r_state;
      w_ready      = 2'b00;
      w_req_hs     = 1'b0;
      case (r_state)
         IDLE: begin
            if ((bus.req_valid_i != 2'b00) && !rst_i) begin
               w_ready      = w_grant_id ? 2'b10 : 2'b01;
               w_req_hs     = 1'b1;
               w_state_next = EXEC;
            end
         end
         EXEC: begin
            w_state_next = RESP;
         end
         RESP: begin
            if (bus.rsp_ready_i) begin
               w_state_next = IDLE;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_prio  <= 1'b0;
         r_id    <= 1'b0;
         r_err   <= 1'b0;
         r_a     <= '0;
         r_b     <= '0;
         r_op    <= 4'd0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_req_hs) begin
            r_a    <= w_a_sel;
            r_b    <= w_b_sel;
            r_op   <= w_op_cap;
            r_id   <= w_grant_id;
            r_err  <= w_op_err;
            r_prio <= ~w_grant_id;
         end
         // Illegal opcodes still spend the EXEC cycle but return zero
         if (r_state == EXEC) begin
            r_data <= r_err ? '0 : bus.alu_data_i;
         end
      end
   end

   assign bus.req_ready_o = w_ready;
   assign bus.alu_a_o     = r_a;
   assign bus.alu_b_o     = r_b;
   assign bus.alu_op_o    = r_op;
   assign bus.rsp_valid_o = (r_state == RESP);
   assign bus.rsp_data_o  = r_data;
   assign bus.rsp_id_o    = r_id;
`ifdef ALU_ARB_OPCHECK_EN
   assign bus.rsp_err_o   = r_err;
`else
   assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed self-checking bench for alu_arbiter with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

   logic clk = 1'b0;
   logic rst;
   int   tot = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.DATA_W(32)) bus();

   alu_arbiter #(.DATA_W(32)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Stand-in for the shared ALU
   always_comb begin
      bus.alu_data_i = 32'd0;
      case (bus.alu_op_o)
         4'd0: bus.alu_data_i = bus.alu_a_o + bus.alu_b_o;
         4'd1: bus.alu_data_i = bus.alu_a_o << bus.alu_b_o[4:0];
         4'd2: bus.alu_data_i = ($signed(bus.alu_a_o) < $signed(bus.alu_b_o)) ? 32'd1 : 32'd0;
         4'd3: bus.alu_data_i = (bus.alu_a_o < bus.alu_b_o) ? 32'd1 : 32'd0;
         4'd4: bus.alu_data_i = bus.alu_a_o ^ bus.alu_b_o;
         4'd5: bus.alu_data_i = bus.alu_a_o >> bus.alu_b_o[4:0];
         4'd6: bus.alu_data_i = $signed(bus.alu_a_o) >>> bus.alu_b_o[4:0];
         4'd7: bus.alu_data_i = bus.alu_a_o | bus.alu_b_o;
         4'd8: bus.alu_data_i = bus.alu_a_o & bus.alu_b_o;
         4'd9: bus.alu_data_i = bus.alu_a_o - bus.alu_b_o;
         default: bus.alu_data_i = 32'd0;
      endcase
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int k, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] op);
      bus.req_a_i[k]     = a;
      bus.req_b_i[k]     = b;
      bus.req_op_i[k]    = op;
      bus.req_valid_i[k] = 1'b1;
   endtask

   task automatic wait_rsp(input string tag);
      for (int i = 0; i < 8 && bus.rsp_valid_o !== 1'b1; i++) tick();
      tot++;
      if (bus.rsp_valid_o !== 1'b1) begin
         bad++;
         $display("FAIL %s_timeout: rsp_valid_o=%b required 1", tag, bus.rsp_valid_o);
      end
   endtask

   task automatic test_reset();
      rst             = 1'b1;
      bus.req_valid_i = 2'b11;
      bus.rsp_ready_i = 1'b0;
      tick();
      tick();
      tot++;
      if (bus.req_ready_o !== 2'b00) begin
         bad++; $display("FAIL reset_ready: got %b required 00", bus.req_ready_o);
      end
      bus.req_valid_i = 2'b00;
      rst = 1'b0;
      tick();
      tot++;
      if (bus.rsp_valid_o !== 1'b0 || bus.rsp_data_o !== 32'd0 || bus.rsp_id_o !== 1'b0 ||
          bus.rsp_err_o !== 1'b0) begin
         bad++; $display("FAIL reset_rsp: valid=%b data=%h id=%b err=%b required 0 0 0 0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o);
      end
      tot++;
      if (bus.alu_a_o !== 32'd0 || bus.alu_b_o !== 32'd0 || bus.alu_op_o !== 4'd0) begin
         bad++; $display("FAIL reset_alu: a=%h b=%h op=%h required 0 0 0",
                         bus.alu_a_o, bus.alu_b_o, bus.alu_op_o);
      end
      tot++;
      if (bus.req_ready_o !== 2'b00) begin
         bad++; $display("FAIL idle_ready: got %b required 00", bus.req_ready_o);
      end
   endtask

   task automatic test_add();
      drive_req(0, 32'd5, 32'd7, 4'd0);
      #1;
      tot++;
      if (bus.req_ready_o !== 2'b01) begin
         bad++; $display("FAIL add_ready: got %b required 01", bus.req_ready_o);
      end
      tick();
      bus.req_valid_i = 2'b00;
      tot++;
      if (bus.alu_a_o !== 32'd5 || bus.alu_b_o !== 32'd7 || bus.alu_op_o !== 4'd0) begin
         bad++; $display("FAIL add_alu_in: a=%h b=%h op=%h required 5 7 0",
                         bus.alu_a_o, bus.alu_b_o, bus.alu_op_o);
      end
      tot++;
      if (bus.rsp_valid_o !== 1'b0 || bus.req_ready_o !== 2'b00) begin
         bad++; $display("FAIL add_exec: rsp_valid=%b ready=%b required 0 00",
                         bus.rsp_valid_o, bus.req_ready_o);
      end
      tick();
      tot++;
      if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'h0000000C ||
          bus.rsp_id_o !== 1'b0 || bus.rsp_err_o !== 1'b0) begin
         bad++; $display("FAIL add_rsp: valid=%b data=%h id=%b err=%b required 1 0000000c 0 0",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.rsp_err_o);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      tot++;
      if (bus.rsp_valid_o !== 1'b0) begin
         bad++; $display("FAIL add_done: rsp_valid=%b required 0", bus.rsp_valid_o);
      end
   endtask

   task automatic test_ops();
      int          k  [3] = '{1, 1, 0};
      logic [31:0] a  [3] = '{32'h80000000, 32'd1, 32'd1};
      logic [31:0] b  [3] = '{32'd4, 32'hFFFFFFFF, 32'hFFFFFFFF};
      logic [3:0]  op [3] = '{4'd6, 4'd3, 4'd2};
      logic [31:0] ex [3] = '{32'hF8000000, 32'd1, 32'd0};
      for (int i = 0; i < 3; i++) begin
         drive_req(k[i], a[i], b[i], op[i]);
         tick();
         bus.req_valid_i = 2'b00;
         wait_rsp("ops");
         tot++;
         if (bus.rsp_data_o !== ex[i] || bus.rsp_id_o !== k[i][0]) begin
            bad++; $display("FAIL ops_%0d: data=%h id=%b required %h %b",
                            i, bus.rsp_data_o, bus.rsp_id_o, ex[i], k[i][0]);
         end
         bus.rsp_ready_i = 1'b1;
         tick();
         bus.rsp_ready_i = 1'b0;
      end
   endtask

   task automatic test_fairness();
      int   n     = 0;
      logic saw11 = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive_req(0, 32'd1, 32'd2, 4'd0);
      drive_req(1, 32'hF0, 32'hFF, 4'd4);
      bus.rsp_ready_i = 1'b1;
      for (int cyc = 0; cyc < 30 && n < 4; cyc++) begin
         tick();
         if (bus.req_ready_o === 2'b11) saw11 = 1'b1;
         if (bus.rsp_valid_o === 1'b1) begin
            tot++;
            if (bus.rsp_id_o !== n[0] || bus.rsp_data_o !== (n[0] ? 32'h0F : 32'd3)) begin
               bad++; $display("FAIL fair_%0d: id=%b data=%h required %b %h",
                               n, bus.rsp_id_o, bus.rsp_data_o, n[0], (n[0] ? 32'h0F : 32'd3));
            end
            n++;
         end
      end
      bus.req_valid_i = 2'b00;
      tick();
      bus.rsp_ready_i = 1'b0;
      tot++;
      if (n != 4) begin
         bad++; $display("FAIL fair_count: got %0d responses required 4", n);
      end
      tot++;
      if (saw11 !== 1'b0) begin
         bad++; $display("FAIL fair_ready11: saw req_ready_o=11, required never");
      end
   endtask

   task automatic test_back_to_back();
      logic bp_bad = 1'b0;
      bus.rsp_ready_i = 1'b0;
      drive_req(0, 32'd10, 32'd3, 4'd9);
      drive_req(1, 32'hF0, 32'h0F, 4'd7);
      wait_rsp("bp");
      tot++;
      if (bus.rsp_data_o !== 32'd7 || bus.rsp_id_o !== 1'b0) begin
         bad++; $display("FAIL bp_first: data=%h id=%b required 00000007 0",
                         bus.rsp_data_o, bus.rsp_id_o);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         if (bus.rsp_valid_o !== 1'b1 || bus.rsp_data_o !== 32'd7 ||
             bus.rsp_id_o !== 1'b0 || bus.req_ready_o !== 2'b00) bp_bad = 1'b1;
      end
      tot++;
      if (bp_bad !== 1'b0) begin
         bad++; $display("FAIL bp_hold: valid=%b data=%h id=%b ready=%b required 1 00000007 0 00",
                         bus.rsp_valid_o, bus.rsp_data_o, bus.rsp_id_o, bus.req_ready_o);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
      tot++;
      if (bus.req_ready_o !== 2'b10 || bus.rsp_valid_o !== 1'b0) begin
         bad++; $display("FAIL bp_regrant: ready=%b rsp_valid=%b required 10 0",
                         bus.req_ready_o, bus.rsp_valid_o);
      end
      tick();
      bus.req_valid_i = 2'b00;
      tot++;
      if (bus.alu_a_o !== 32'hF0 || bus.alu_op_o !== 4'd7) begin
         bad++; $display("FAIL bp_second_in: a=%h op=%h required 000000f0 7",
                         bus.alu_a_o, bus.alu_op_o);
      end
      wait_rsp("bp2");
      tot++;
      if (bus.rsp_data_o !== 32'hFF || bus.rsp_id_o !== 1'b1) begin
         bad++; $display("FAIL bp_second: data=%h id=%b required 000000ff 1",
                         bus.rsp_data_o, bus.rsp_id_o);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_opcheck();
`ifdef ALU_ARB_OPCHECK_EN
      logic [3:0] exp_op  = 4'd0;
      logic       exp_err = 1'b1;
`else
      logic [3:0] exp_op  = 4'hC;
      logic       exp_err = 1'b0;
`endif
      drive_req(0, 32'd3, 32'd4, 4'hC);
      tick();
      bus.req_valid_i = 2'b00;
      tot++;
      if (bus.alu_op_o !== exp_op) begin
         bad++; $display("FAIL opchk_op: got %h required %h", bus.alu_op_o, exp_op);
      end
      wait_rsp("opchk");
      tot++;
      if (bus.rsp_data_o !== 32'd0 || bus.rsp_err_o !== exp_err) begin
         bad++; $display("FAIL opchk_rsp: data=%h err=%b required 00000000 %b",
                         bus.rsp_data_o, bus.rsp_err_o, exp_err);
      end
      bus.rsp_ready_i = 1'b1;
      tick();
      bus.rsp_ready_i = 1'b0;
   endtask

   task automatic test_reset_exec();
      logic leaked = 1'b0;
      drive_req(0, 32'd5, 32'd7, 4'd0);
      tick();
      bus.req_valid_i = 2'b00;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tot++;
      if (bus.rsp_valid_o !== 1'b0 || bus.alu_a_o !== 32'd0 || bus.alu_b_o !== 32'd0) begin
         bad++; $display("FAIL rstexec_out: rsp_valid=%b a=%h b=%h required 0 0 0",
                         bus.rsp_valid_o, bus.alu_a_o, bus.alu_b_o);
      end
      bus.rsp_ready_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (bus.rsp_valid_o === 1'b1) leaked = 1'b1;
      end
      bus.rsp_ready_i = 1'b0;
      tot++;
      if (leaked !== 1'b0) begin
         bad++; $display("FAIL rstexec_leak: discarded op produced a response, required none");
      end
      bus.req_valid_i = 2'b11;
      #1;
      tot++;
      if (bus.req_ready_o !== 2'b01) begin
         bad++; $display("FAIL rstexec_prio: ready=%b required 01", bus.req_ready_o);
      end
      bus.req_valid_i = 2'b00;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst             = 1'b1;
      bus.req_valid_i = 2'b00;
      bus.req_a_i     = '0;
      bus.req_b_i     = '0;
      bus.req_op_i    = '0;
      bus.rsp_ready_i = 1'b0;
      test_reset();
      test_add();
      test_ops();
      test_fairness();
      test_back_to_back();
      test_opcheck();
      test_reset_exec();
      $display("test done: total=%0d bad=%0d", tot, bad);
      $finish;
   end

endmodule

`default_nettype wire
